// File: rtl/program_sequencer.sv
// ----------------------------------------------------------------------------
// program_sequencer
//   Walks a program ROM one instruction at a time: fetches a word, issues a
//   one-cycle run pulse to the processor control FSM, waits for done (with a
//   timeout), then advances. Supports single-step pausing, a halt opcode,
//   and a two-word mvi instruction whose immediate follows the opcode word.
//
// Ports
//   clk         : sole clock, rising edge
//   rst         : asynchronous active-high reset
//   start       : level; begins the program at address 0 from IDLE/HALT/ERR
//   step_mode   : 1 = enter PAUSE after every completed instruction
//   step        : single-cycle pulse releasing PAUSE
//   done        : instruction-complete flag from the processor
//   data_read   : ROM word at addr (1-cycle read latency), [8:6] = opcode
//   addr        : program ROM address
//   run         : one-cycle pulse starting one processor instruction
//   busy        : high in FETCH, ISSUE, EXEC, PAUSE
//   halted      : high in HALT
//   err         : high in ERR
//   instr_count : instructions completed since start (saturating)
//   state       : IDLE=0 FETCH=1 ISSUE=2 EXEC=3 PAUSE=4 HALT=5 ERR=6
// ----------------------------------------------------------------------------
module program_sequencer #(
    parameter int unsigned LAST_ADDR = 31,
    parameter int unsigned TIMEOUT   = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       step_mode,
    input  logic       step,
    input  logic       done,
    input  logic [8:0] data_read,
    output logic [4:0] addr,
    output logic       run,
    output logic       busy,
    output logic       halted,
    output logic       err,
    output logic [7:0] instr_count,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_ISSUE = 3'd2,
        S_EXEC  = 3'd3,
        S_PAUSE = 3'd4,
        S_HALT  = 3'd5,
        S_ERR   = 3'd6
    } state_t;

    // Timeout counter only needs to reach TIMEOUT-1 before the ERR decision.
    localparam int unsigned    TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [4:0]     LAST     = LAST_ADDR[4:0];
    localparam logic [2:0]     OP_MVI   = 3'b001;
    localparam logic [2:0]     OP_HALT  = 3'b111;

    state_t        state_q, state_d;
    logic [4:0]    addr_q, addr_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          busy_q, busy_d;
    logic          halted_q, halted_d;
    logic          err_q, err_d;

    logic [2:0] opcode;
    logic       at_last;

    assign opcode  = data_read[8:6];
    assign at_last = (addr_q == LAST);

    // Operand bits are consumed by the processor, not by the sequencer.
    logic unused_operand;
    assign unused_operand = ^data_read[5:0];

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        // run is decoded from the ROM word visible during ISSUE, so it cannot
        // be a flop without delaying it out of the ISSUE cycle.
        run     = 1'b0;
        case (state_q)
            S_IDLE, S_HALT, S_ERR: begin
                if (start) begin
                    state_d = S_FETCH;
                    addr_d  = '0;
                    cnt_d   = '0;
                end
            end
            S_FETCH: state_d = S_ISSUE;
            S_ISSUE: begin
                if (opcode == OP_HALT) begin
                    state_d = S_HALT;
                end else if (opcode == OP_MVI && at_last) begin
                    state_d = S_ERR;
                end else begin
                    run     = 1'b1;
                    tmo_d   = '0;
                    state_d = S_EXEC;
                    // Point the ROM at the immediate word while the processor runs.
                    if (opcode == OP_MVI) begin
                        addr_d = addr_q + 5'd1;
                    end
                end
            end
            S_EXEC: begin
                if (done) begin
                    tmo_d = '0;
                    if (cnt_q != 8'hFF) begin
                        cnt_d = cnt_q + 8'd1;
                    end
                    if (at_last) begin
                        state_d = S_HALT;
                    end else begin
                        addr_d  = addr_q + 5'd1;
                        state_d = step_mode ? S_PAUSE : S_FETCH;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d = S_ERR;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_PAUSE: begin
                if (step || !step_mode) begin
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
                addr_d  = '0;
                cnt_d   = '0;
                tmo_d   = '0;
            end
        endcase

        busy_d   = (state_d == S_FETCH) || (state_d == S_ISSUE) ||
                   (state_d == S_EXEC)  || (state_d == S_PAUSE);
        halted_d = (state_d == S_HALT);
        err_d    = (state_d == S_ERR);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            cnt_q    <= '0;
            tmo_q    <= '0;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            tmo_q    <= tmo_d;
            busy_q   <= busy_d;
            halted_q <= halted_d;
            err_q    <= err_d;
        end
    end

    assign addr        = addr_q;
    assign busy        = busy_q;
    assign halted      = halted_q;
    assign err         = err_q;
    assign instr_count = cnt_q;
    assign state       = state_q;

endmodule

// File: tb/tb_program_sequencer.sv
module tb_program_sequencer;

    localparam int LAST = 31;
    localparam int TMO  = 15;

    localparam logic [8:0] MV   = 9'h000;
    localparam logic [8:0] MVI  = 9'h040;
    localparam logic [8:0] ADD  = 9'h080;
    localparam logic [8:0] SUB  = 9'h0C0;
    localparam logic [8:0] HLT  = 9'h1C0;
    localparam logic [8:0] IMM5 = 9'h005;

    logic       clk = 1'b0;
    logic       rst, start, step_mode, step, done;
    logic [8:0] data_read;
    logic [4:0] addr;
    logic       run, busy, halted, err;
    logic [7:0] instr_count;
    logic [2:0] state;

    program_sequencer #(.LAST_ADDR(LAST), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .start(start), .step_mode(step_mode), .step(step),
        .done(done), .data_read(data_read), .addr(addr), .run(run), .busy(busy),
        .halted(halted), .err(err), .instr_count(instr_count), .state(state)
    );

    always #5 clk = ~clk;

    // Synchronous ROM model
    logic [8:0] rom [32];
    always @(posedge clk) data_read <= rom[addr];

    // Per-run done latency (0 = never answer)
    int lat_arr [64];
    int exp_run [64];
    int run_base = 0;
    logic done_force = 1'b0;

    // Processor responder + run monitor
    int         run_cnt  = 0;
    int         viol_cnt = 0;
    int         cd       = -1;
    logic       prev_run = 1'b0;
    logic       resp_done = 1'b0;
    logic [4:0] obs_addr [2048];

    assign done = resp_done | done_force;

    always @(negedge clk) begin
        resp_done = 1'b0;
        if (rst) begin
            cd = -1;
        end else if (run) begin
            if (prev_run || state != 3'd2) viol_cnt++;
            if (run_cnt < 2048) obs_addr[run_cnt] = addr;
            if (run_cnt - run_base >= 0 && run_cnt - run_base < 64)
                cd = (lat_arr[run_cnt - run_base] == 0) ? -1 : lat_arr[run_cnt - run_base];
            else
                cd = -1;
            run_cnt++;
        end else if (cd > 0) begin
            cd--;
            if (cd == 0) begin
                resp_done = 1'b1;
                cd = -1;
            end
        end
        prev_run = run;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // Program-level reference: walks the ROM instruction by instruction.
    task automatic model(output int es, output int ea, output int ec,
                         output int er, output int ecy);
        int pc, cnt, k, cyc, l;
        logic [2:0] op;
        pc = 0; cnt = 0; k = 0; cyc = 0; es = 5;
        for (int it = 0; it < 64; it++) begin
            op = rom[pc][8:6];
            if (op == 3'b111) begin cyc += 2; es = 5; break; end
            if (op == 3'b001 && pc == LAST) begin cyc += 2; es = 6; break; end
            exp_run[k] = pc;
            k++;
            if (op == 3'b001) pc++;
            l = lat_arr[k-1];
            if (l == 0 || l > TMO) begin cyc += 2 + TMO; es = 6; break; end
            cyc += 2 + l;
            if (cnt < 255) cnt++;
            if (pc == LAST) begin es = 5; break; end
            pc++;
        end
        ea = pc; ec = cnt; er = k; ecy = cyc;
    endtask

    task automatic wait_state(input logic [2:0] s, input int lim, input string nm);
        int n = 0;
        while (state !== s && n < lim) begin @(negedge clk); n++; end
        chk(nm, 32'(state), 32'(s));
    endtask

    task automatic exec_prog(input logic sm, output int n_cyc, output int n_runs);
        int n = 0;
        run_base = run_cnt;
        @(negedge clk); step_mode = sm; start = 1'b1;
        @(negedge clk); start = 1'b0;
        while (!(state == 3'd5 || state == 3'd6) && n < 3000) begin @(negedge clk); n++; end
        if (n >= 3000) chk("terminal_reached", 0, 1);
        n_cyc = n;
        n_runs = run_cnt - run_base;
    endtask

    task automatic check_runs(input string nm, input int er, input int nr);
        for (int i = 0; i < er && i < nr; i++)
            chk(nm, 32'(obs_addr[run_base + i]), 32'(exp_run[i]));
    endtask

    typedef struct packed {
        logic [8:0] w0, w1, w2, w3, w30, w31, fill;
        logic [4:0] lat;
        logic [2:0] es;
        logic [4:0] ea;
        logic [7:0] ec;
        logic [7:0] er;
        logic [9:0] ecy;
    } vec_t;

    task automatic load_vec(input vec_t v);
        for (int i = 0; i < 32; i++) rom[i] = v.fill;
        rom[0] = v.w0; rom[1] = v.w1; rom[2] = v.w2; rom[3] = v.w3;
        rom[30] = v.w30; rom[31] = v.w31;
        for (int j = 0; j < 64; j++) lat_arr[j] = int'(v.lat);
    endtask

    vec_t vecs [9];

    initial begin
        int es, ea, ec, er, ecy, nc, nr, v0;
        vecs[0] = '{MV,  ADD,  SUB, HLT, HLT, HLT, HLT, 5'd3,  3'd5, 5'd3,  8'd3,  8'd3,  10'd17};
        vecs[1] = '{MVI, IMM5, HLT, HLT, HLT, HLT, HLT, 5'd3,  3'd5, 5'd2,  8'd1,  8'd1,  10'd7};
        vecs[2] = '{MV,  HLT,  HLT, HLT, HLT, HLT, HLT, 5'd0,  3'd6, 5'd0,  8'd0,  8'd1,  10'd17};
        vecs[3] = '{MV,  MV,   MV,  MV,  MV,  MV,  MV,  5'd1,  3'd5, 5'd31, 8'd32, 8'd32, 10'd96};
        vecs[4] = '{MV,  MV,   MV,  MV,  MV,  MVI, MV,  5'd1,  3'd6, 5'd31, 8'd31, 8'd31, 10'd95};
        vecs[5] = '{HLT, HLT,  HLT, HLT, HLT, HLT, HLT, 5'd3,  3'd5, 5'd0,  8'd0,  8'd0,  10'd2};
        vecs[6] = '{MV,  HLT,  HLT, HLT, HLT, HLT, HLT, 5'd15, 3'd5, 5'd1,  8'd1,  8'd1,  10'd19};
        vecs[7] = '{MV,  MV,   MV,  MV,  MVI, HLT, MV,  5'd2,  3'd5, 5'd31, 8'd31, 8'd31, 10'd124};
        vecs[8] = '{MVI, HLT,  ADD, HLT, HLT, HLT, HLT, 5'd2,  3'd5, 5'd3,  8'd2,  8'd2,  10'd10};

        for (int i = 0; i < 32; i++) rom[i] = HLT;
        for (int j = 0; j < 64; j++) lat_arr[j] = 3;
        rst = 1'b1; start = 1'b0; step_mode = 1'b0; step = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_state", 32'(state), 0);
        chk("rst_addr", 32'(addr), 0);
        chk("rst_run", 32'(run), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_count", 32'(instr_count), 0);
        rst = 1'b0;
        run_base = run_cnt;
        repeat (5) @(negedge clk);
        chk("idle_no_run", 32'(run_cnt - run_base), 0);
        chk("idle_holds", 32'(state), 0);

        // Table-driven programs
        for (int t = 0; t < 9; t++) begin
            load_vec(vecs[t]);
            model(es, ea, ec, er, ecy);
            exec_prog(1'b0, nc, nr);
            chk("vec_state", 32'(state), 32'(vecs[t].es));
            chk("vec_addr", 32'(addr), 32'(vecs[t].ea));
            chk("vec_count", 32'(instr_count), 32'(vecs[t].ec));
            chk("vec_halted", 32'(halted), 32'(vecs[t].es == 3'd5));
            chk("vec_err", 32'(err), 32'(vecs[t].es == 3'd6));
            chk("vec_busy", 32'(busy), 0);
            chk("vec_runs", 32'(nr), 32'(vecs[t].er));
            chk("vec_cycles", 32'(nc), 32'(vecs[t].ecy));
            check_runs("vec_run_addr", er, nr);
        end

        // mvi immediate timing
        load_vec(vecs[1]);
        for (int j = 0; j < 64; j++) lat_arr[j] = 4;
        model(es, ea, ec, er, ecy);
        run_base = run_cnt;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk("mvi_fetch_state", 32'(state), 1);
        chk("mvi_fetch_busy", 32'(busy), 1);
        @(negedge clk);
        chk("mvi_issue_run", 32'(run), 1);
        chk("mvi_issue_addr", 32'(addr), 0);
        @(negedge clk);
        chk("mvi_exec_addr", 32'(addr), 1);
        chk("mvi_exec_run", 32'(run), 0);
        @(negedge clk);
        chk("mvi_imm_word", 32'(data_read), 32'(IMM5));
        @(negedge clk);
        chk("mvi_imm_stable", 32'(data_read), 32'(IMM5));
        wait_state(3'd5, 40, "mvi_halt_reached");
        chk("mvi_final_addr", 32'(addr), 2);
        chk("mvi_final_count", 32'(instr_count), 1);

        // Single-step mode
        load_vec(vecs[0]);
        model(es, ea, ec, er, ecy);
        run_base = run_cnt;
        @(negedge clk); step_mode = 1'b1; start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_state(3'd4, 40, "step_pause1");
        chk("step_pause1_count", 32'(instr_count), 1);
        chk("step_pause1_addr", 32'(addr), 1);
        repeat (4) @(negedge clk);
        chk("step_pause_holds", 32'(state), 4);
        chk("step_no_extra_run", 32'(run_cnt - run_base), 1);
        done_force = 1'b1;
        @(negedge clk); done_force = 1'b0;
        chk("done_in_pause_ignored", 32'(instr_count), 1);
        step = 1'b1;
        @(negedge clk); step = 1'b0;
        chk("step_to_fetch", 32'(state), 1);
        wait_state(3'd3, 10, "step_exec2");
        step = 1'b1;
        @(negedge clk); step = 1'b0;
        chk("step_in_exec_ignored", 32'(state), 3);
        wait_state(3'd4, 40, "step_pause2");
        chk("step_pause2_count", 32'(instr_count), 2);
        step_mode = 1'b0;
        @(negedge clk);
        chk("stepmode_clear_fetch", 32'(state), 1);
        wait_state(3'd5, 60, "step_halt");
        chk("step_final_addr", 32'(addr), 3);
        chk("step_final_count", 32'(instr_count), 3);
        chk("step_runs", 32'(run_cnt - run_base), 3);
        check_runs("step_run_addr", er, run_cnt - run_base);

        // Reset during EXEC, then restart
        for (int i = 0; i < 32; i++) rom[i] = MV;
        for (int j = 0; j < 64; j++) lat_arr[j] = 10;
        run_base = run_cnt;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        v0 = 0;
        while (!(state == 3'd3 && addr == 5'd2) && v0 < 100) begin @(negedge clk); v0++; end
        chk("rst_exec_reached", 32'(v0 < 100), 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_state", 32'(state), 0);
        chk("arst_addr", 32'(addr), 0);
        chk("arst_count", 32'(instr_count), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_run", 32'(run), 0);
        @(negedge clk); rst = 1'b0;
        run_base = run_cnt;
        repeat (6) @(negedge clk);
        chk("post_rst_idle", 32'(state), 0);
        chk("post_rst_no_run", 32'(run_cnt - run_base), 0);
        for (int i = 0; i < 32; i++) rom[i] = HLT;
        rom[0] = MV;
        for (int j = 0; j < 64; j++) lat_arr[j] = 2;
        model(es, ea, ec, er, ecy);
        exec_prog(1'b0, nc, nr);
        chk("restart_state", 32'(state), 5);
        chk("restart_addr", 32'(addr), 1);
        chk("restart_count", 32'(instr_count), 1);
        chk("restart_cycles", 32'(nc), 6);
        chk("restart_runs", 32'(nr), 1);
        check_runs("restart_run_addr", er, nr);

        // Randomized programs against the reference
        for (int p = 0; p < 25; p++) begin
            for (int i = 0; i < 32; i++) begin
                int r;
                logic [2:0] op;
                r = int'($urandom_range(0, 99));
                if (r < 6) op = 3'b111;
                else if (r < 20) op = 3'b001;
                else if (r < 30) op = 3'b000;
                else op = 3'($urandom_range(2, 6));
                rom[i] = {op, 6'($urandom)};
            end
            for (int j = 0; j < 64; j++)
                lat_arr[j] = ($urandom_range(0, 24) == 0) ? 0 : int'($urandom_range(1, TMO));
            model(es, ea, ec, er, ecy);
            exec_prog(1'b0, nc, nr);
            chk("rnd_state", 32'(state), 32'(es));
            chk("rnd_addr", 32'(addr), 32'(ea));
            chk("rnd_count", 32'(instr_count), 32'(ec));
            chk("rnd_err", 32'(err), 32'(es == 6));
            chk("rnd_runs", 32'(nr), 32'(er));
            chk("rnd_cycles", 32'(nc), 32'(ecy));
            check_runs("rnd_run_addr", er, nr);
        end

        chk("run_protocol_violations", 32'(viol_cnt), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
